// File: rtl/sdram_port_arbiter_if.sv
// Bundle between the SDRAM port arbiter and its three requesters
// (VGA line fill, CPU, DMA) plus the SDRAM controller command port.
// Ports: vga_*  VGA burst-read requester side
//        cpu_*  CPU single-word requester side
//        dma_*  DMA burst-write requester side
//        mem_*  SDRAM controller command/data side
//        dbg_owner  current owner (0 none, 1 VGA, 2 CPU, 3 DMA)
// Modports: slave = arbiter, master = requesters and controller.
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 24
) ();

   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_grant;
   logic [15:0]       vga_data;
   logic              vga_valid;
   logic              vga_done;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [15:0]       cpu_wdata;
   logic [15:0]       cpu_rdata;
   logic              cpu_ack;

   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic [15:0]       dma_wdata;
   logic              dma_grant;
   logic              dma_wdata_rd;
   logic              dma_done;

   logic              mem_cmd_valid;
   logic              mem_cmd_ready;
   logic              mem_cmd_we;
   logic [ADDR_W-1:0] mem_cmd_addr;
   logic [7:0]        mem_cmd_len;
   logic [15:0]       mem_wdata;
   logic              mem_wdata_rd;
   logic [15:0]       mem_rdata;
   logic              mem_rvalid;
   logic              mem_done;

   logic [1:0]        dbg_owner;

   modport slave (
      input  vga_req, vga_addr,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_addr, dma_wdata,
      input  mem_cmd_ready, mem_wdata_rd,
      input  mem_rdata, mem_rvalid, mem_done,
      output vga_grant, vga_data, vga_valid, vga_done,
      output cpu_rdata, cpu_ack,
      output dma_grant, dma_wdata_rd, dma_done,
      output mem_cmd_valid, mem_cmd_we,
      output mem_cmd_addr, mem_cmd_len, mem_wdata,
      output dbg_owner
   );

   modport master (
      output vga_req, vga_addr,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_addr, dma_wdata,
      output mem_cmd_ready, mem_wdata_rd,
      output mem_rdata, mem_rvalid, mem_done,
      input  vga_grant, vga_data, vga_valid, vga_done,
      input  cpu_rdata, cpu_ack,
      input  dma_grant, dma_wdata_rd, dma_done,
      input  mem_cmd_valid, mem_cmd_we,
      input  mem_cmd_addr, mem_cmd_len, mem_wdata,
      input  dbg_owner
   );

endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between VGA (strict
// priority burst reads), CPU (single word) and DMA (burst writes).
// Ports: clk_sys  system clock
//        rst      asynchronous active-high reset
//        bus      requester + controller bundle (slave side)
// CPU and DMA alternate round-robin; one command in flight at a time.
module sdram_port_arbiter #(
   parameter int BURST_LEN = 128,
   parameter int ADDR_W    = 24
) (
   input logic                  clk_sys,
   input logic                  rst,
   sdram_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      XFER,
      RELEASE
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_VGA  = 2'd1;
   localparam logic [1:0] OWN_CPU  = 2'd2;
   localparam logic [1:0] OWN_DMA  = 2'd3;
   localparam logic [7:0] BLEN     = 8'(BURST_LEN);

   state_t     state;
   logic [1:0] owner;
   logic [1:0] pick;
   logic       rr_dma;
   logic       own_vga;
   logic       own_cpu;
   logic       own_dma;

   // rr_dma set means DMA is favoured when CPU and DMA both ask.
   always_comb begin
      pick = OWN_NONE;
      if (bus.vga_req)
         pick = OWN_VGA;
      else if (bus.cpu_req && bus.dma_req)
         pick = rr_dma ? OWN_DMA : OWN_CPU;
      else if (bus.cpu_req)
         pick = OWN_CPU;
      else if (bus.dma_req)
         pick = OWN_DMA;
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         owner             <= OWN_NONE;
         rr_dma            <= 1'b0;
         bus.vga_grant     <= 1'b0;
         bus.dma_grant     <= 1'b0;
         bus.mem_cmd_valid <= 1'b0;
         bus.mem_cmd_we    <= 1'b0;
         bus.mem_cmd_addr  <= '0;
         bus.mem_cmd_len   <= '0;
         bus.cpu_rdata     <= '0;
      end else begin
         if (own_cpu && bus.mem_rvalid)
            bus.cpu_rdata <= bus.mem_rdata;
         unique case (state)
            IDLE: begin
               if (pick != OWN_NONE) begin
                  state             <= ISSUE;
                  owner             <= pick;
                  bus.mem_cmd_valid <= 1'b1;
                  unique case (pick)
                     OWN_VGA: begin
                        bus.mem_cmd_we   <= 1'b0;
                        bus.mem_cmd_addr <= bus.vga_addr;
                        bus.mem_cmd_len  <= BLEN;
                        bus.vga_grant    <= 1'b1;
                     end
                     OWN_CPU: begin
                        bus.mem_cmd_we   <= bus.cpu_we;
                        bus.mem_cmd_addr <= bus.cpu_addr;
                        bus.mem_cmd_len  <= 8'd1;
                        rr_dma           <= 1'b1;
                     end
                     OWN_DMA: begin
                        bus.mem_cmd_we   <= 1'b1;
                        bus.mem_cmd_addr <= bus.dma_addr;
                        bus.mem_cmd_len  <= BLEN;
                        bus.dma_grant    <= 1'b1;
                        rr_dma           <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            ISSUE: begin
               if (bus.mem_cmd_ready) begin
                  bus.mem_cmd_valid <= 1'b0;
                  state             <= XFER;
               end
            end
            XFER: begin
               // Ownership ends with done so the RELEASE cycle
               // ignores any stray controller strobes.
               if (bus.mem_done) begin
                  state         <= RELEASE;
                  owner         <= OWN_NONE;
                  bus.vga_grant <= 1'b0;
                  bus.dma_grant <= 1'b0;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign own_vga = (owner == OWN_VGA);
   assign own_cpu = (owner == OWN_CPU);
   assign own_dma = (owner == OWN_DMA);

   assign bus.dbg_owner    = owner;
   assign bus.vga_data     = own_vga ? bus.mem_rdata : 16'h0;
   assign bus.vga_valid    = own_vga & bus.mem_rvalid;
   assign bus.vga_done     = own_vga & bus.mem_done;
   assign bus.cpu_ack      = own_cpu & bus.mem_done;
   assign bus.dma_done     = own_dma & bus.mem_done;
   assign bus.dma_wdata_rd = own_dma & bus.mem_wdata_rd;

   always_comb begin
      bus.mem_wdata = 16'h0;
      unique case (1'b1)
         own_cpu: bus.mem_wdata = bus.cpu_wdata;
         own_dma: bus.mem_wdata = bus.dma_wdata;
         default: bus.mem_wdata = 16'h0;
      endcase
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table of single
// transactions plus arbitration, back-pressure and reset sequences.
module tb_sdram_port_arbiter;

   localparam int AW = 24;
   localparam int BL = 128;

   typedef struct {
      logic [1:0]  owner;
      logic        we;
      logic [23:0] addr;
      logic [7:0]  len;
      int          vcyc;
      logic [15:0] wdata;
   } cmd_t;

   typedef struct {
      logic [1:0]  port;
      logic        we;
      logic [23:0] addr;
      logic [15:0] wdata;
      int          rdy;
      bit          gaps;
      logic        exp_we;
      logic [7:0]  exp_len;
      int          beats;
      logic [15:0] rdata;
   } vec_t;

   logic clk_sys = 1'b0;
   logic rst = 1'b1;
   always #5 clk_sys = ~clk_sys;

   sdram_port_arbiter_if #(.ADDR_W(AW)) bus ();

   sdram_port_arbiter #(
      .BURST_LEN(BL),
      .ADDR_W(AW)
   ) dut (
      .clk_sys(clk_sys),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   cmd_t sb[$];

   int vga_iss = 0, cpu_iss = 0, dma_iss = 0;
   int vga_srv = 0, cpu_srv = 0, dma_srv = 0;
   int ready_delay = 0;
   bit gap_mode = 1'b0;

   logic [1:0]  cur_own = 2'd0;
   int          vcyc = 0;
   logic        prev_valid = 1'b0;
   logic [32:0] prev_fields = '0;
   int          last_done = -100;
   int gap3 = 0, gap_bad = 0, unstable = 0;
   int gate_err = 0, own_err = 0, grant_err = 0, data_err = 0;
   int n_vv = 0, n_vd = 0, n_ack = 0, n_dd = 0, n_pop = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(posedge clk_sys) cyc++;

   // Requesters hold req until their completion strobe is seen.
   always @(posedge clk_sys) begin
      #1;
      bus.vga_req   = (vga_iss != vga_srv);
      bus.cpu_req   = (cpu_iss != cpu_srv);
      bus.dma_req   = (dma_iss != dma_srv);
      bus.dma_wdata = 16'hD000 + 16'(n_pop);
   end

   task automatic serve();
      logic we;
      int n;
      logic [15:0] base;
      for (int k = 0; k < ready_delay; k++) begin
         @(posedge clk_sys); #1;
         if (rst) return;
      end
      bus.mem_cmd_ready = 1'b1;
      we   = bus.mem_cmd_we;
      n    = int'(bus.mem_cmd_len);
      base = bus.mem_cmd_addr[15:0];
      @(posedge clk_sys); #1;
      bus.mem_cmd_ready = 1'b0;
      if (rst) return;
      for (int i = 0; i < n; i++) begin
         if (we) bus.mem_wdata_rd = 1'b1;
         else begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = base ^ 16'(i);
         end
         @(posedge clk_sys); #1;
         bus.mem_wdata_rd = 1'b0;
         bus.mem_rvalid   = 1'b0;
         if (rst) return;
         if (gap_mode && (i % 3 == 1)) begin
            @(posedge clk_sys); #1;
            if (rst) return;
         end
      end
      bus.mem_done = 1'b1;
      @(posedge clk_sys); #1;
      bus.mem_done = 1'b0;
   endtask

   initial begin : ctrl
      bus.mem_cmd_ready = 1'b0;
      bus.mem_wdata_rd  = 1'b0;
      bus.mem_rdata     = 16'h0;
      bus.mem_rvalid    = 1'b0;
      bus.mem_done      = 1'b0;
      forever begin
         @(posedge clk_sys); #1;
         bus.mem_cmd_ready = 1'b0;
         bus.mem_wdata_rd  = 1'b0;
         bus.mem_rvalid    = 1'b0;
         bus.mem_done      = 1'b0;
         if (rst) bus.mem_rdata = 16'h0;
         else if (bus.mem_cmd_valid) serve();
      end
   end

   task automatic accept();
      cmd_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_cmd: got addr %0h want none",
                  bus.mem_cmd_addr);
      end else begin
         e = sb.pop_front();
         chk("cmd_owner", 32'(bus.dbg_owner), 32'(e.owner));
         chk("cmd_we", 32'(bus.mem_cmd_we), 32'(e.we));
         chk("cmd_addr", 32'(bus.mem_cmd_addr), 32'(e.addr));
         chk("cmd_len", 32'(bus.mem_cmd_len), 32'(e.len));
         chk("cmd_valid_cycles", vcyc, e.vcyc);
         if (e.owner == 2'd2 && e.we)
            chk("cpu_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
      end
      vcyc = 0;
   endtask

   always @(negedge clk_sys) begin
      if (rst) begin
         cur_own    = 2'd0;
         vcyc       = 0;
         prev_valid = 1'b0;
         last_done  = -100;
      end else begin
         if (bus.mem_cmd_valid) begin
            if (!prev_valid) begin
               if (cyc - last_done == 3) gap3++;
               else if (cyc - last_done < 3) gap_bad++;
               if (sb.size() > 0) cur_own = sb[0].owner;
            end else if ({bus.mem_cmd_we, bus.mem_cmd_addr,
                          bus.mem_cmd_len} != prev_fields)
               unstable++;
            prev_fields = {bus.mem_cmd_we, bus.mem_cmd_addr,
                           bus.mem_cmd_len};
            vcyc++;
            if (bus.mem_cmd_ready) accept();
         end
         prev_valid = bus.mem_cmd_valid;
         if (bus.dbg_owner !== cur_own) own_err++;
         if ({bus.vga_grant, bus.dma_grant} !==
             {cur_own == 2'd1, cur_own == 2'd3})
            grant_err++;
         if (bus.vga_valid !== (bus.mem_rvalid && cur_own == 2'd1))
            gate_err++;
         if (bus.vga_done !== (bus.mem_done && cur_own == 2'd1))
            gate_err++;
         if (bus.cpu_ack !== (bus.mem_done && cur_own == 2'd2))
            gate_err++;
         if (bus.dma_done !== (bus.mem_done && cur_own == 2'd3))
            gate_err++;
         if (bus.dma_wdata_rd !== (bus.mem_wdata_rd && cur_own == 2'd3))
            gate_err++;
         if (bus.mem_rvalid && cur_own == 2'd1 &&
             bus.vga_data !== bus.mem_rdata)
            data_err++;
         if (bus.mem_wdata_rd && cur_own == 2'd3 &&
             bus.mem_wdata !== 16'hD000 + 16'(n_pop))
            data_err++;
         if (bus.vga_valid) n_vv++;
         if (bus.vga_done) begin n_vd++; vga_srv++; end
         if (bus.cpu_ack) begin n_ack++; cpu_srv++; end
         if (bus.dma_done) begin n_dd++; dma_srv++; end
         if (bus.dma_wdata_rd) n_pop++;
         if (bus.mem_done && cur_own != 2'd0) begin
            last_done = cyc;
            cur_own   = 2'd0;
         end
      end
   end

   task automatic wait_srv(input string name, input int bound);
      bit ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk_sys); #1;
         if (vga_srv == vga_iss && cpu_srv == cpu_iss &&
             dma_srv == dma_iss) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, "_complete"}, 32'(ok), 32'd1);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_strobes"}, 32'({bus.vga_grant, bus.vga_valid,
          bus.vga_done, bus.cpu_ack, bus.dma_grant, bus.dma_wdata_rd,
          bus.dma_done, bus.mem_cmd_valid, bus.mem_cmd_we,
          bus.dbg_owner}), 32'd0);
      chk({nm, "_cmd_addr"}, 32'(bus.mem_cmd_addr), 32'd0);
      chk({nm, "_cmd_len"}, 32'(bus.mem_cmd_len), 32'd0);
      chk({nm, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'd0);
      chk({nm, "_data"}, 32'({bus.mem_wdata, bus.vga_data}), 32'd0);
   endtask

   function automatic cmd_t mk(input logic [1:0] o, input logic we,
                               input logic [23:0] a, input logic [7:0] l,
                               input int vc, input logic [15:0] wd);
      cmd_t c;
      c.owner = o; c.we = we; c.addr = a;
      c.len = l; c.vcyc = vc; c.wdata = wd;
      return c;
   endfunction

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: summary not reached in time");
      $fatal(1);
   end

   initial begin : main
      vec_t tbl[6];
      int s_vv, s_vd, s_ack, s_dd, s_pop, s_g3, s_gb;
      bit hit;

      tbl[0] = '{2'd1, 1'b0, 24'h000400, 16'h0000, 0, 1'b0,
                 1'b0, 8'd128, 128, 16'h0000};
      tbl[1] = '{2'd2, 1'b0, 24'h00ABCD, 16'h0000, 2, 1'b0,
                 1'b0, 8'd1, 0, 16'hABCD};
      tbl[2] = '{2'd2, 1'b1, 24'h123456, 16'hBEEF, 5, 1'b0,
                 1'b1, 8'd1, 0, 16'h0000};
      tbl[3] = '{2'd3, 1'b0, 24'h200000, 16'h0000, 1, 1'b1,
                 1'b1, 8'd128, 128, 16'h0000};
      tbl[4] = '{2'd2, 1'b0, 24'hFFFFFF, 16'h0000, 0, 1'b0,
                 1'b0, 8'd1, 0, 16'hFFFF};
      tbl[5] = '{2'd3, 1'b0, 24'h000000, 16'h0000, 0, 1'b0,
                 1'b1, 8'd128, 128, 16'h0000};

      bus.vga_addr  = '0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = 16'h0;
      bus.dma_addr  = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk_sys);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk_sys); #1;

      for (int i = 0; i < 6; i++) begin
         ready_delay = tbl[i].rdy;
         gap_mode    = tbl[i].gaps;
         case (tbl[i].port)
            2'd1: bus.vga_addr = tbl[i].addr;
            2'd2: begin
               bus.cpu_we    = tbl[i].we;
               bus.cpu_addr  = tbl[i].addr;
               bus.cpu_wdata = tbl[i].wdata;
            end
            default: bus.dma_addr = tbl[i].addr;
         endcase
         sb.push_back(mk(tbl[i].port, tbl[i].exp_we, tbl[i].addr,
                         tbl[i].exp_len, tbl[i].rdy + 1, tbl[i].wdata));
         s_vv = n_vv; s_vd = n_vd; s_ack = n_ack;
         s_dd = n_dd; s_pop = n_pop;
         case (tbl[i].port)
            2'd1: vga_iss++;
            2'd2: cpu_iss++;
            default: dma_iss++;
         endcase
         wait_srv($sformatf("vec%0d", i), 2000);
         case (tbl[i].port)
            2'd1: begin
               chk($sformatf("vec%0d_vga_valid", i), n_vv - s_vv,
                   tbl[i].beats);
               chk($sformatf("vec%0d_vga_done", i), n_vd - s_vd, 1);
            end
            2'd2: begin
               chk($sformatf("vec%0d_cpu_ack", i), n_ack - s_ack, 1);
               if (!tbl[i].we)
                  chk($sformatf("vec%0d_cpu_rdata", i),
                      32'(bus.cpu_rdata), 32'(tbl[i].rdata));
            end
            default: begin
               chk($sformatf("vec%0d_dma_pops", i), n_pop - s_pop,
                   tbl[i].beats);
               chk($sformatf("vec%0d_dma_done", i), n_dd - s_dd, 1);
            end
         endcase
         repeat (2) @(negedge clk_sys);
         #1;
      end

      // VGA, CPU and DMA all asking in the same IDLE cycle.
      ready_delay   = 0;
      gap_mode      = 1'b0;
      bus.vga_addr  = 24'h000800;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 24'h000010;
      bus.dma_addr  = 24'h300000;
      sb.push_back(mk(2'd1, 1'b0, 24'h000800, 8'd128, 1, 16'h0));
      sb.push_back(mk(2'd2, 1'b0, 24'h000010, 8'd1, 1, 16'h0));
      sb.push_back(mk(2'd3, 1'b1, 24'h300000, 8'd128, 1, 16'h0));
      s_g3 = gap3; s_gb = gap_bad;
      vga_iss++; cpu_iss++; dma_iss++;
      wait_srv("three", 3000);
      chk("three_drained", sb.size(), 0);
      chk("three_dead_gaps", gap3 - s_g3, 2);
      chk("three_short_gaps", gap_bad - s_gb, 0);
      repeat (2) @(negedge clk_sys);
      #1;

      // CPU and DMA held together must alternate.
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 24'h000020;
      bus.cpu_wdata = 16'h1234;
      bus.dma_addr  = 24'h400000;
      for (int k = 0; k < 2; k++) begin
         sb.push_back(mk(2'd2, 1'b1, 24'h000020, 8'd1, 1, 16'h1234));
         sb.push_back(mk(2'd3, 1'b1, 24'h400000, 8'd128, 1, 16'h0));
      end
      s_g3 = gap3;
      cpu_iss += 2; dma_iss += 2;
      wait_srv("alt", 3000);
      chk("alt_drained", sb.size(), 0);
      chk("alt_dead_gaps", gap3 - s_g3, 3);
      repeat (2) @(negedge clk_sys);
      #1;

      // Reset in the middle of a VGA burst.
      bus.vga_addr = 24'h000400;
      sb.push_back(mk(2'd1, 1'b0, 24'h000400, 8'd128, 1, 16'h0));
      s_vv = n_vv;
      vga_iss++;
      hit = 1'b0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk_sys); #1;
         if (n_vv - s_vv >= 50) begin
            hit = 1'b1;
            break;
         end
      end
      chk("rst_burst_reached_word50", 32'(hit), 32'd1);
      @(posedge clk_sys); #2;
      rst = 1'b1;
      #1;
      chk_zero("rst_mid");
      vga_iss = vga_srv;
      sb.delete();
      repeat (2) @(negedge clk_sys);
      #1;
      rst = 1'b0;
      @(negedge clk_sys); #1;
      chk("post_rst_owner", 32'(bus.dbg_owner), 32'd0);
      bus.vga_addr = 24'h000900;
      sb.push_back(mk(2'd1, 1'b0, 24'h000900, 8'd128, 1, 16'h0));
      s_vd = n_vd;
      vga_iss++;
      @(negedge clk_sys); #1;
      chk("post_rst_req_cycle_valid",
          32'({bus.mem_cmd_valid, bus.vga_grant}), 32'd0);
      @(negedge clk_sys); #1;
      chk("post_rst_next_cycle_valid",
          32'({bus.mem_cmd_valid, bus.vga_grant}), 32'd3);
      chk("post_rst_addr", 32'(bus.mem_cmd_addr), 32'h000900);
      wait_srv("post_rst", 2000);
      chk("post_rst_vga_done", n_vd - s_vd, 1);
      repeat (2) @(negedge clk_sys);
      #1;

      chk("cmd_fields_stable", unstable, 0);
      chk("strobe_gating", gate_err, 0);
      chk("owner_tracking", own_err, 0);
      chk("grant_window", grant_err, 0);
      chk("data_routing", data_err, 0);
      chk("dead_cycle_min", gap_bad, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM controller command port between three requesters on the 100 MHz system clock. The requesters are the VGA line-fill engine (128-word burst reads), the CPU (single-word read/write) and the DMA/blitter (128-word burst writes). The VGA port has strict, non-preemptive priority. CPU and DMA alternate round-robin. The arbiter issues one command at a time, routes burst data to and from the owner, and generates per-port grant/done/ack strobes.

## Interface
Parameters:
- BURST_LEN, 128: words per VGA read burst and per DMA write burst (1..255).
- ADDR_W, 24: SDRAM word-address width.

Ports:
- clk_sys  in  1  100 MHz system clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- vga_req  in  1  line-fill request; held until vga_done.
- vga_addr  in  ADDR_W  burst start address; stable while vga_req is high.
- vga_grant  out  1  high from command issue through the vga_done cycle.
- vga_data  out  16  read data (mem_rdata pass-through).
- vga_valid  out  1  mem_rvalid gated by VGA ownership.
- vga_done  out  1  mem_done gated by VGA ownership.
- cpu_req  in  1  single-word access request; held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  registered read data.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req  in  1  burst-write request; held until dma_done.
- dma_addr  in  ADDR_W  burst start address.
- dma_wdata  in  16  current write word (FWFT).
- dma_grant  out  1  high from command issue through the dma_done cycle.
- dma_wdata_rd  out  1  pop strobe for dma_wdata.
- dma_done  out  1  burst-complete pulse.
- mem_cmd_valid  out  1  command valid to the SDRAM controller.
- mem_cmd_ready  in  1  controller accepts the command.
- mem_cmd_we  out  1  write command.
- mem_cmd_addr  out  ADDR_W  command address.
- mem_cmd_len  out  8  words in this command.
- mem_wdata  out  16  write data to the controller.
- mem_wdata_rd  in  1  controller consumes mem_wdata this cycle.
- mem_rdata  in  16  read data.
- mem_rvalid  in  1  read data valid.
- mem_done  in  1  command complete (one-cycle pulse).
- dbg_owner  out  2  0 = none, 1 = VGA, 2 = CPU, 3 = DMA.

## Operation
- States: IDLE, ISSUE, XFER, RELEASE.
- IDLE → ISSUE:
  - Priority is vga_req > round-robin(cpu_req, dma_req).
  - The round-robin pointer favours the port not served last and updates only on CPU/DMA wins.
  - On entry the arbiter registers owner, mem_cmd_we, mem_cmd_addr and mem_cmd_len:
    - VGA: we = 0, len = BURST_LEN.
    - CPU: we = cpu_we, len = 1.
    - DMA: we = 1, len = BURST_LEN.
  - It also sets mem_cmd_valid and the owner's grant.
- ISSUE → XFER: when mem_cmd_ready = 1. mem_cmd_valid drops the next cycle. All command fields stay stable while valid is high.
- XFER → RELEASE: when mem_done = 1.
- RELEASE → IDLE: unconditionally. Grants deassert in RELEASE, which forces one dead cycle between commands. This lets registered requesters drop req after done.
- Data routing while owned:
  - vga_valid = mem_rvalid.
  - cpu_rdata captures mem_rdata on mem_rvalid.
  - mem_wdata = cpu_wdata when the owner is CPU, dma_wdata when the owner is DMA, else 0.
  - dma_wdata_rd = mem_wdata_rd when the owner is DMA.
- Completion strobes (valid only for the owning port):
  - vga_done = mem_done.
  - dma_done = mem_done.
  - cpu_ack = mem_done.
- mem_rvalid, mem_wdata_rd and mem_done arriving with no owner are ignored.
- A requester dropping req after it wins arbitration does not abort the command; the transaction completes.
- There is no preemption: a VGA request arriving during a DMA burst waits until RELEASE.

## Timing
- Reset (asynchronous):
  - State = IDLE, owner = 0, round-robin pointer = CPU.
  - Every output is 0: grants, strobes, mem_cmd_*, cpu_rdata, dbg_owner.
  - Reset mid-burst abandons the transaction. The controller is reset by the same rst.
- Latency: a request sampled in IDLE at cycle t gives mem_cmd_valid and grant at t+1.
- Data and done strobes are combinational from mem_* (zero added latency).
- With mem_done at cycle d:
  - Grant stays high at d and is low at d+1 (RELEASE).
  - The earliest next mem_cmd_valid is at d+3.
- cpu_rdata is valid from the cycle after mem_rvalid and holds until the next CPU read.
- Throughput:
  - Minimum occupancy per command is 4 cycles plus controller latency.
  - The VGA worst-case wait is one DMA burst plus 3 cycles.

## Test plan
- **VGA only.** Raise vga_req with vga_addr = 0x000400, controller returns 128 rvalid words then done. Required:
  - mem_cmd_addr = 0x000400, len = 128, we = 0.
  - 128 vga_valid pulses, exactly one vga_done.
  - vga_grant low the cycle after done.
- **All three requests in the same IDLE cycle.** Required order: VGA, CPU, DMA, with dbg_owner sequence 1, 2, 3 and one dead cycle between each.
- **CPU and DMA both held continuously.** Required: strict alternation CPU, DMA, CPU, DMA, with no port granted twice in a row.
- **CPU write 0xBEEF to 0x123456 with mem_cmd_ready held low for 5 cycles.** Required:
  - mem_cmd_valid and all command fields stable for 6 cycles.
  - mem_wdata = 0xBEEF.
  - cpu_ack pulses once, on mem_done.
- **DMA burst with mem_wdata_rd asserted on 128 non-contiguous cycles.** Required: exactly 128 dma_wdata_rd pulses, aligned cycle-for-cycle with mem_wdata_rd.
- **Assert rst during an in-flight VGA burst (word 50).** Required:
  - All outputs 0 immediately.
  - After release, state is IDLE and a new vga_req is issued at t+1.
